// File: rtl/lipsi_mem_pkg.sv
// lipsi_mem_pkg: shared widths, owner encoding and counter sizing for the memory arbiter.
package lipsi_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int HOST_MAX_WAIT_DEFAULT = 8;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} mem_owner_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of cycles a pending request has been denied.
module arb_wait_counter
    import lipsi_mem_pkg::*;
#(
    parameter int MAX = HOST_MAX_WAIT_DEFAULT,
    localparam int W = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         gnt,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    logic [W-1:0] cnt_d, cnt_q;

    assign at_max = cnt_q == W'(MAX);
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = (!req || gnt) ? '0 : at_max ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lipsi_mem_arbiter.sv
// lipsi_mem_arbiter: grants the shared memory to the core or host each cycle,
// drives the memory command pins and flags read data one cycle after a read grant.
module lipsi_mem_arbiter
    import lipsi_mem_pkg::*;
#(
    parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_fetch,
    input  logic              cpu_small,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_wr_en,
    output logic              mem_fetch,
    output logic              mem_small_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam int W = cnt_width(HOST_MAX_WAIT);

    mem_owner_t   owner, rd_owner_d, rd_owner_q;
    logic [W-1:0] wait_cnt;
    logic         wait_at_max, is_cpu, is_host;

    arb_wait_counter #(.MAX(HOST_MAX_WAIT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .req    (host_req),
        .gnt    (host_gnt),
        .cnt    (wait_cnt),
        .at_max (wait_at_max)
    );

    always_comb begin
        owner = reset ? OWN_NONE
              : (host_req && (!cpu_req || wait_at_max)) ? OWN_HOST
              : cpu_req ? OWN_CPU : OWN_NONE;
        is_cpu         = owner == OWN_CPU;
        is_host        = owner == OWN_HOST;
        cpu_gnt        = is_cpu;
        host_gnt       = is_host;
        mem_fetch      = is_cpu & cpu_fetch;
        mem_small_addr = is_cpu & cpu_small & ~cpu_fetch;
        mem_wr_en      = is_cpu ? (cpu_we & ~cpu_fetch) : (is_host & host_we);
        mem_rd_addr    = is_cpu ? cpu_addr : is_host ? host_addr : '0;
        mem_wr_addr    = mem_rd_addr;
        mem_wr_data    = is_cpu ? cpu_wdata : is_host ? host_wdata : '0;
        rd_owner_d     = (is_cpu && (cpu_fetch || !cpu_we)) ? OWN_CPU
                       : (is_host && !host_we) ? OWN_HOST : OWN_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_owner_q <= OWN_NONE;
        else       rd_owner_q <= rd_owner_d;
    end

    assign cpu_rvalid  = rd_owner_q == OWN_CPU;
    assign host_rvalid = rd_owner_q == OWN_HOST;
    assign cpu_rdata   = mem_rd_data;
    assign host_rdata  = mem_rd_data;

    // The starvation count can never exceed its saturation point.
    assert property (@(posedge clk) disable iff (reset) wait_cnt <= W'(HOST_MAX_WAIT));
endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
// tb_lipsi_mem_arbiter: randomized and directed checks of the arbiter against
// a transaction-level model of grants, starvation and memory contents.
module tb_lipsi_mem_arbiter;
    localparam int MAXW = 8;

    logic       clk = 0, reset = 1;
    logic       cpu_req = 0, cpu_fetch = 0, cpu_small = 0, cpu_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0;
    logic       host_req = 0, host_we = 0;
    logic [7:0] host_addr = 0, host_wdata = 0;
    logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [7:0] cpu_rdata, host_rdata;
    logic       mem_wr_en, mem_fetch, mem_small_addr;
    logic [7:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;

    int errors = 0, checks = 0;

    lipsi_mem_arbiter #(.HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_fetch(cpu_fetch), .cpu_small(cpu_small), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_wr_en(mem_wr_en), .mem_fetch(mem_fetch), .mem_small_addr(mem_small_addr),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 256) ? 8'hC7 : 8'(i * 7 + 1);
    endfunction

    // 512x8 memory: program loaded while reset is high, synchronous read and write.
    logic [7:0] mem [512];
    logic [8:0] rd_idx, wr_idx;
    assign rd_idx = mem_fetch ? {1'b1, mem_rd_addr} : mem_small_addr ? {5'b0, mem_rd_addr[3:0]} : {1'b0, mem_rd_addr};
    assign wr_idx = mem_small_addr ? {5'b0, mem_wr_addr[3:0]} : {1'b0, mem_wr_addr};
    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
        else if (mem_wr_en) mem[wr_idx] <= mem_wr_data;
        mem_rd_data <= mem[rd_idx];
    end

    // Reference model: expected owner (0 none, 1 core, 2 host), starvation count, memory image, pending read.
    logic [7:0] ref_mem [512];
    int         wcnt = 0, e_own = 0, pend = 0;
    logic [7:0] pend_data = 0, e_addr = 0;

    task automatic apply(input logic cr, cf, cs, cw, input logic [7:0] ca, cd,
                         input logic hr, hw, input logic [7:0] ha, hd);
        cpu_req = cr; cpu_fetch = cf; cpu_small = cs; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        e_own  = reset ? 0 : (hr && (!cr || wcnt == MAXW)) ? 2 : cr ? 1 : 0;
        e_addr = (e_own == 1) ? ca : (e_own == 2) ? ha : 8'h00;
        #1;
    endtask

    task automatic advance();
        int idx;
        @(posedge clk);
        if (reset) begin
            wcnt = 0; pend = 0;
            for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        end else begin
            pend = 0;
            if (e_own == 1) begin
                idx = cpu_fetch ? 256 + int'(cpu_addr) : cpu_small ? int'(cpu_addr[3:0]) : int'(cpu_addr);
                if (cpu_fetch || !cpu_we) begin pend = 1; pend_data = ref_mem[idx]; end
                else ref_mem[idx] = cpu_wdata;
            end else if (e_own == 2) begin
                if (!host_we) begin pend = 2; pend_data = ref_mem[host_addr]; end
                else ref_mem[host_addr] = host_wdata;
            end
            wcnt = (!host_req || e_own == 2) ? 0 : (wcnt < MAXW) ? wcnt + 1 : wcnt;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        apply(1, 0, 0, 1, 8'h12, 8'h34, 1, 1, 8'h56, 8'h78);
        checks++;
        if ({cpu_gnt, host_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {cpu_gnt, host_gnt}); end
        checks++;
        if ({mem_wr_en, mem_fetch, mem_small_addr, mem_rd_addr, mem_wr_addr, mem_wr_data} !== 27'd0) begin
            errors++; $display("FAIL reset_mem_cmd: got wr=%b f=%b s=%b ra=%h wa=%h wd=%h want all 0",
                               mem_wr_en, mem_fetch, mem_small_addr, mem_rd_addr, mem_wr_addr, mem_wr_data);
        end
        advance(); advance();
        checks++;
        if ({cpu_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {cpu_rvalid, host_rvalid}); end
        reset = 0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_fetch();
        apply(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        checks++;
        if ({cpu_gnt, mem_fetch} !== 2'b11) begin errors++; $display("FAIL fetch_gnt: got gnt=%b fetch=%b want 1 1", cpu_gnt, mem_fetch); end
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hC7) begin errors++; $display("FAIL fetch_data: got v=%b d=%h want 1 c7", cpu_rvalid, cpu_rdata); end
        advance();
    endtask

    task automatic test_host_rw();
        apply(0, 0, 0, 0, 0, 0, 1, 1, 8'h03, 8'h5A);
        checks++;
        if ({host_gnt, mem_wr_en} !== 2'b11) begin errors++; $display("FAIL host_wr_cmd: got gnt=%b we=%b want 1 1", host_gnt, mem_wr_en); end
        advance();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 8'h03, 8'h00);
        checks++;
        if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_wr_norvalid: got %b want 0", host_rvalid); end
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h5A) begin errors++; $display("FAIL host_rd: got v=%b d=%h want 1 5a", host_rvalid, host_rdata); end
        advance();
    endtask

    task automatic test_small();
        apply(0, 0, 0, 0, 0, 0, 1, 1, 8'h03, 8'h11);
        advance();
        apply(1, 0, 1, 0, 8'hF3, 8'h00, 0, 0, 0, 0);
        checks++;
        if (mem_small_addr !== 1'b1 || mem_rd_addr[3:0] !== 4'd3) begin
            errors++; $display("FAIL small_addr: got s=%b a=%h want 1 x3", mem_small_addr, mem_rd_addr);
        end
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h11) begin errors++; $display("FAIL small_data: got v=%b d=%h want 1 11", cpu_rvalid, cpu_rdata); end
        advance();
    endtask

    task automatic test_fetch_we();
        apply(1, 1, 0, 1, 8'h03, 8'hEE, 0, 0, 0, 0);
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL fetch_we_wren: got %b want 0", mem_wr_en); end
        advance();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 8'h03, 8'h00);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h11) begin errors++; $display("FAIL fetch_we_mem: got v=%b d=%h want 1 11", host_rvalid, host_rdata); end
        advance();
    endtask

    task automatic test_starvation();
        bit hwin;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        for (int k = 0; k < 27; k++) begin
            hwin = (k % (MAXW + 1)) == MAXW;
            apply(1, 1, 0, 0, 8'(k), 0, 1, 0, 8'(k), 0);
            checks++;
            if (host_gnt !== hwin || cpu_gnt !== !hwin) begin
                errors++; $display("FAIL starve_gnt k=%0d: got cpu=%b host=%b want host=%b", k, cpu_gnt, host_gnt, hwin);
            end
            advance();
            checks++;
            if (host_rvalid !== hwin || cpu_rvalid !== !hwin) begin
                errors++; $display("FAIL starve_rvalid k=%0d: got cpu=%b host=%b want host=%b", k, cpu_rvalid, host_rvalid, hwin);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
        advance();
        reset = 1;
        apply(1, 0, 0, 0, 8'h20, 0, 1, 0, 8'h10, 0);
        checks++;
        if (host_rvalid !== 1'b1 || {cpu_gnt, host_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_enter: got rv=%b gnt=%b want 1 00", host_rvalid, {cpu_gnt, host_gnt});
        end
        advance();
        checks++;
        if ({cpu_rvalid, host_rvalid, cpu_gnt, host_gnt} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_drop: got rv=%b gnt=%b want 00 00", {cpu_rvalid, host_rvalid}, {cpu_gnt, host_gnt});
        end
        advance();
        reset = 0;
        apply(1, 0, 0, 0, 8'h20, 0, 1, 0, 8'h10, 0);
        checks++;
        if (host_gnt !== 1'b0 || cpu_gnt !== 1'b1) begin errors++; $display("FAIL reset_mid_after: got cpu=%b host=%b want 1 0", cpu_gnt, host_gnt); end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(9, 0) < 7, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
                  8'($urandom), 8'($urandom),
                  $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, 8'($urandom_range(15, 0)), 8'($urandom));
            checks++;
            if (cpu_gnt !== (e_own == 1) || host_gnt !== (e_own == 2)) begin
                errors++; $display("FAIL rand_gnt n=%0d: got cpu=%b host=%b want owner %0d", n, cpu_gnt, host_gnt, e_own);
            end
            checks++;
            if (mem_rd_addr !== e_addr || mem_wr_addr !== e_addr) begin
                errors++; $display("FAIL rand_addr n=%0d: got ra=%h wa=%h want %h", n, mem_rd_addr, mem_wr_addr, e_addr);
            end
            advance();
            checks++;
            if (cpu_rvalid !== (pend == 1) || host_rvalid !== (pend == 2) || (pend != 0 && cpu_rdata !== pend_data)) begin
                errors++; $display("FAIL rand_read n=%0d: got cv=%b hv=%b d=%h want pend %0d d=%h",
                                   n, cpu_rvalid, host_rvalid, cpu_rdata, pend, pend_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_host_rw();
        test_small();
        test_fetch_we();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
